// File: rtl/generador_rampa_pwm_pkg.sv
// Shared constants and control-state encoding for the PWM ramp generator,
// its comparator stage and the top level.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH       = 10;
    localparam int unsigned PWM_TOP_DEFAULT = 1023;

    // Shadow register status: IDLE has nothing queued, PENDING waits for a wrap.
    typedef enum logic {
        CTRL_IDLE    = 1'b0,
        CTRL_PENDING = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/generador_rampa_pwm_contador_modulo.sv
// Free-running modulo counter: counts 0..top and returns to 0.
// 'wrap' flags the current cycle as a wrap edge so the parent can act on the same edge.
module contador_modulo
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = enable && (count == top);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/generador_rampa_pwm.sv
// PWM ramp generator: modulo counter plus double-buffered duty/period registers
// that only take new values at a period boundary.
module generador_rampa_pwm
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH       = PWM_WIDTH,
    parameter logic [WIDTH-1:0] TOP_DEFAULT = WIDTH'(PWM_TOP_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] top_in,
    input  logic             duty_load,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] duty_q,
    output logic [WIDTH-1:0] top_q,
    output logic             period_end,
    output logic             update_ack,
    output logic             pending
);

    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] top_shadow;
    logic             wrap;
    ctrl_state_t      state;

    contador_modulo #(
        .WIDTH(WIDTH)
    ) u_contador (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .top    (top_q),
        .count  (count),
        .wrap   (wrap)
    );

    assign pending = (state == CTRL_PENDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q      <= '0;
            top_q       <= TOP_DEFAULT;
            duty_shadow <= '0;
            top_shadow  <= '0;
            state       <= CTRL_IDLE;
            period_end  <= 1'b0;
            update_ack  <= 1'b0;
        end else begin
            period_end <= wrap;
            update_ack <= wrap && (state == CTRL_PENDING);

            if (wrap && (state == CTRL_PENDING)) begin
                duty_q <= duty_shadow;
                top_q  <= top_shadow;
                state  <= CTRL_IDLE;
            end

            // Placed after the commit: a load on a wrap edge commits the old
            // shadow and leaves the new value pending for the next wrap.
            if (duty_load) begin
                duty_shadow <= duty_in;
                top_shadow  <= top_in;
                state       <= CTRL_PENDING;
            end
        end
    end

endmodule
